// File: rtl/fft_pkg.sv
// fft_pkg: shared state encodings, frame descriptor and arbitration helper for the bit-reverse scheduler
package fft_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  typedef struct packed {
    logic is_real;
    logic tag;
  } frame_t;
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    return req[ptr] ? ptr : ~ptr;
  endfunction
endpackage

// File: rtl/rr_frame_arbiter.sv
// rr_frame_arbiter: two-way round-robin frame grant; the pointer moves past the winner when its frame completes
module rr_frame_arbiter
  import fft_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_req,
  input  logic       i_arb,
  input  logic       i_done,
  output logic       o_grant
);
  logic ptr;
  // latch the winner at frame start, rotate priority at frame end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      ptr     <= 1'b0;
      o_grant <= 1'b0;
    end else begin
      if (i_arb) o_grant <= rr_pick(i_req, ptr);
      if (i_done) ptr <= ~o_grant;
    end
endmodule

// File: rtl/fft_bitrev_scheduler.sv
// fft_bitrev_scheduler: shares one ping-pong bit-reverse buffer between two FFT streams, frame by frame
module fft_bitrev_scheduler
  import fft_pkg::*;
#(
  parameter int LGSIZE       = 5,
  parameter int WIDTH        = 24,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [1:0]         i_valid,
  input  logic [2*WIDTH-1:0] i_data0,
  input  logic [2*WIDTH-1:0] i_data1,
  output logic [1:0]         o_ready,
  output logic               o_br_ce,
  output logic [2*WIDTH-1:0] o_br_data,
  input  logic [2*WIDTH-1:0] i_br_out,
  input  logic               i_br_sync,
  output logic               o_valid,
  output logic [2*WIDTH-1:0] o_data,
  output logic               o_tag,
  output logic               o_first,
  output logic               o_busy
);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  logic [1:0]        state;
  logic              grant;
  logic [LGSIZE-1:0] cnt;
  logic [TW-1:0]     idle_cnt;
  frame_t [1:0]      frames;
  logic              pending, last, start, timeout;
  assign pending   = frames[1].is_real;
  assign last      = o_br_ce & (&cnt);
  assign start     = (state == S_IDLE) & (|i_valid);
  assign timeout   = (state == S_IDLE) & ~(|i_valid) & pending & (idle_cnt == TW'(IDLE_TIMEOUT));
  assign o_ready   = (state == S_FILL) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign o_br_ce   = (state == S_FLUSH) | (|(o_ready & i_valid));
  assign o_br_data = (state == S_FILL) ? (grant ? i_data1 : i_data0) : '0;
  assign o_data    = i_br_out;
  assign o_first   = o_valid & i_br_sync;
  assign o_busy    = (state != S_IDLE) | pending;
  rr_frame_arbiter u_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_valid),
    .i_arb     (start),
    .i_done    (last & (state == S_FILL)),
    .o_grant   (grant)
  );
  // frame sequencing: sample counter wraps once per frame, idle counter saturates at the flush threshold
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= start ? S_FILL : timeout ? S_FLUSH : last ? S_IDLE : state;
      cnt      <= o_br_ce ? cnt + 1'b1 : cnt;
      idle_cnt <= (o_br_ce | (state == S_FILL)) ? '0 :
                  ((state == S_IDLE) & (idle_cnt != TW'(IDLE_TIMEOUT))) ? idle_cnt + 1'b1 : idle_cnt;
    end
  // [0] describes the frame being written, captured with its first sample; [1] is the frame now draining
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      frames <= '0;
    end else begin
      if (o_br_ce && cnt == '0) frames[0] <= {state == S_FILL, grant};
      if (last) frames[1] <= frames[0];
    end
  // buffer output lags its clock-enable by one cycle, so valid and tag are delayed to match
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_tag   <= 1'b0;
    end else begin
      o_valid <= o_br_ce & frames[1].is_real;
      if (o_br_ce) o_tag <= frames[1].tag;
    end
endmodule
